aes_round_ctrl: RTL and testbench



---
 rtl/aes_round_ctrl.sv | 119 +++++++++++
 tb/tb_aes_round_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps the datapath through AddRoundKey, NR-1 full rounds and the final round.
// Optional macro AES_ROUND_HOLD_EN adds a round_hold input that freezes the sequence.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          reset,
`ifdef AES_ROUND_HOLD_EN
    input  logic          round_hold,
`endif
    input  logic          round_en,
    output logic [RW-1:0] round_num,
    output logic [7:0]    rcon,
    output logic          load_key,
    output logic          mix_en,
    output logic          last_round,
    output logic          round_ctrl,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [RW-1:0] r_round_num;
    logic [7:0]    r_rcon;
    logic          r_load_key;
    logic          r_mix_en;
    logic          r_last_round;
    logic          r_round_ctrl;
    logic          r_busy;
    logic          w_hold;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_round_num  <= '0;
            r_rcon       <= '0;
            r_load_key   <= 1'b0;
            r_mix_en     <= 1'b0;
            r_last_round <= 1'b0;
            r_round_ctrl <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (round_en) begin
                        r_state    <= S_INIT;
                        r_load_key <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_INIT, S_ROUND, S_FINAL: begin
                    // Abort outranks hold; FINAL->DONE clears outputs the same way.
                    if (!round_en || (!w_hold && r_state == S_FINAL)) begin
                        r_state      <= round_en ? S_DONE : S_IDLE;
                        r_round_num  <= '0;
                        r_rcon       <= '0;
                        r_load_key   <= 1'b0;
                        r_mix_en     <= 1'b0;
                        r_last_round <= 1'b0;
                        r_round_ctrl <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (!w_hold) begin
                        if (r_state == S_INIT) begin
                            r_state     <= S_ROUND;
                            r_round_num <= RW'(1);
                            r_rcon      <= 8'h01;
                            r_load_key  <= 1'b0;
                            r_mix_en    <= 1'b1;
                        end else begin
                            r_round_num <= r_round_num + RW'(1);
                            r_rcon      <= xtime(r_rcon);
                            if (r_round_num == RW'(NR - 1)) begin
                                r_state      <= S_FINAL;
                                r_mix_en     <= 1'b0;
                                r_last_round <= 1'b1;
                                r_round_ctrl <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!round_en) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AES_ROUND_HOLD_EN
    assign w_hold     = round_hold;
    // The pulse is withheld while frozen in FINAL and appears on the releasing cycle.
    assign round_ctrl = r_round_ctrl & ~round_hold;
`else
    assign w_hold     = 1'b0;
    assign round_ctrl = r_round_ctrl;
`endif

    assign round_num  = r_round_num;
    assign rcon       = r_rcon;
    assign load_key   = r_load_key;
    assign mix_en     = r_mix_en;
    assign last_round = r_last_round;
    assign busy       = r_busy;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: directed and random round_en/reset against a run-position model.
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          round_en;
    logic [RW-1:0] round_num;
    logic [7:0]    rcon;
    logic          load_key;
    logic          mix_en;
    logic          last_round;
    logic          round_ctrl;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int pulses = 0;
    logic [7:0] rc_tab [NR + 1];
    logic [7:0] lit_rcon [10];

    aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .round_en   (round_en),
        .round_num  (round_num),
        .rcon       (rcon),
        .load_key   (load_key),
        .mix_en     (mix_en),
        .last_round (last_round),
        .round_ctrl (round_ctrl),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // k = cycles since the run started: 0 idle, 1 INIT, 2..NR rounds, NR+1 final, NR+2 done.
    function automatic logic [RW+12:0] exp_vec(input int kk);
        logic [RW-1:0] n;
        logic [7:0]    r;
        logic          lk, mx, lr, rc, b;
        n = '0; r = '0; lk = 0; mx = 0; lr = 0; rc = 0; b = 0;
        if (kk == 1) begin
            lk = 1; b = 1;
        end else if (kk >= 2 && kk <= NR) begin
            n = RW'(kk - 1); r = rc_tab[kk - 1]; mx = 1; b = 1;
        end else if (kk == NR + 1) begin
            n = RW'(NR); r = rc_tab[NR]; lr = 1; rc = 1; b = 1;
        end
        return {n, r, lk, mx, lr, rc, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic rst);
        round_en = en;
        reset    = rst;
        @(posedge clk);
        if (rst)               k = 0;
        else if (k == 0)       k = en ? 1 : 0;
        else if (k <= NR + 1)  k = en ? k + 1 : 0;
        else                   k = en ? k : 0;
        #1;
        if (round_ctrl === 1'b1) pulses++;
        check("outputs", 32'({round_num, rcon, load_key, mix_en, last_round, round_ctrl, busy}),
              32'(exp_vec(k)));
    endtask

    initial begin
        rc_tab[0] = 8'h00;
        rc_tab[1] = 8'h01;
        for (int i = 2; i <= NR; i++)
            rc_tab[i] = 8'((int'(rc_tab[i-1]) * 2) % 256) ^ ((rc_tab[i-1] >= 8'h80) ? 8'h1b : 8'h00);
        lit_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        reset = 1'b1;
        round_en = 1'b0;
        step(0, 1);
        step(0, 1);
        for (int i = 0; i < 5; i++) step(0, 0);
        check("idle_busy", busy, 0);

        pulses = 0;
        for (int i = 1; i <= NR + 2; i++) begin
            step(1, 0);
            if (i == 1) check("load_key_c1", load_key, 1);
            if (i >= 2 && i <= NR) check("rcon_round", rcon, lit_rcon[i-2]);
            if (i == NR + 1) begin
                check("final_rcon", rcon, lit_rcon[9]);
                check("final_num", round_num, NR);
                check("final_ctrl", round_ctrl, 1);
            end
        end
        check("done_clear", {load_key, mix_en, last_round, round_ctrl, busy}, 0);
        for (int i = 0; i < 5; i++) step(1, 0);
        check("one_pulse", pulses, 1);
        check("no_restart", busy, 0);

        step(0, 0);
        step(1, 0);
        check("restart_num", round_num, 0);
        check("restart_load", load_key, 1);
        for (int i = 0; i < 5; i++) step(1, 0);
        check("abort_at5", round_num, 5);
        pulses = 0;
        step(0, 0);
        check("abort_num", round_num, 0);
        check("abort_rcon", rcon, 0);
        for (int i = 1; i <= NR + 2; i++) begin
            step(1, 0);
            if (i == 2) check("after_abort_rcon", rcon, 8'h01);
        end
        check("after_abort_pulse", pulses, 1);

        step(0, 0);
        for (int i = 0; i < 8; i++) step(1, 0);
        check("pre_reset_num", round_num, 7);
        step(1, 1);
        check("reset_mid_busy", busy, 0);
        check("reset_mid_num", round_num, 0);
        pulses = 0;
        step(1, 0);
        check("post_reset_init", load_key, 1);
        for (int i = 0; i < NR + 1; i++) step(1, 0);
        check("post_reset_pulse", pulses, 1);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
